// File: rtl/fu_logical_pkg.sv
// ============================================================================
// Module      : fu_logical_pkg
// Description : Opcode enumeration, AArch64 condition codes and condition
//               evaluation shared by the logical functional unit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fu_logical_pkg;

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_ORR   = 4'd1,
    OP_EOR   = 4'd2,
    OP_BIC   = 4'd3,
    OP_ORN   = 4'd4,
    OP_MVN   = 4'd5,
    OP_ANDS  = 4'd6,
    OP_CSEL  = 4'd7,
    OP_CSINC = 4'd8,
    OP_CSINV = 4'd9,
    OP_CSNEG = 4'd10,
    OP_UBFM  = 4'd11,
    OP_SBFM  = 4'd12
  } logic_op_e;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_NV = 4'b1111;

  // nzcv is packed {N,Z,C,V}; NV (1111) behaves like AL rather than inverting.
  function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond[3:1])
      3'b000:  r = z;
      3'b001:  r = c;
      3'b010:  r = n;
      3'b011:  r = v;
      3'b100:  r = c & ~z;
      3'b101:  r = (n == v);
      3'b110:  r = ~z & (n == v);
      default: r = 1'b1;
    endcase
    if (cond[0] && (cond != COND_NV)) r = ~r;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fu_logical_pipe_bfm.sv
// ============================================================================
// Module      : fu_bfm
// Description : Combinational UBFM/SBFM bitfield extract/insert-at-zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_bfm #(
  parameter int XLEN = 64
) (
  input  logic [XLEN-1:0] a_i,
  input  logic [5:0]      r_i,
  input  logic [5:0]      s_i,
  input  logic            sf_i,
  input  logic            signed_i,
  output logic [XLEN-1:0] y_o
);

  logic            w64;
  logic [6:0]      wsz, rr, ss, top;
  logic [XLEN-1:0] aw, field, fill, sh;

  // Mask of the n low bits; n may equal XLEN, hence the extra guard bit.
  function automatic logic [XLEN-1:0] lowmask(input logic [6:0] n);
    logic [XLEN:0] t;
    t = ({{XLEN{1'b0}}, 1'b1} << n) - {{XLEN{1'b0}}, 1'b1};
    return t[XLEN-1:0];
  endfunction

  always_comb begin
    w64 = (XLEN == 64) && sf_i;
    wsz = w64 ? 7'd64 : 7'd32;
    rr  = w64 ? {1'b0, r_i} : {2'b00, r_i[4:0]};
    ss  = w64 ? {1'b0, s_i} : {2'b00, s_i[4:0]};
    aw  = a_i & lowmask(wsz);
    if (ss >= rr) begin
      field = (aw >> rr) & lowmask(ss - rr + 7'd1);
      top   = ss - rr;
    end else begin
      field = (aw & lowmask(ss + 7'd1)) << (wsz - rr);
      top   = wsz - rr + ss;
    end
    // a[s] is the field's top bit in both placements
    sh   = aw >> ss;
    fill = (signed_i && sh[0]) ? ~lowmask(top + 7'd1) : '0;
    y_o  = (field | fill) & lowmask(wsz);
  end

endmodule

`default_nettype wire

// File: rtl/fu_logical_pipe.sv
// ============================================================================
// Module      : fu_logical_pipe
// Description : Pipelined logical/conditional-select/bitfield functional unit
//               with valid/ready handshake, backpressure and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fu_logical_pipe
  import fu_logical_pkg::*;
#(
  parameter int XLEN    = 64,
  parameter int LATENCY = 1,
  parameter int PRN_W   = 7,
  parameter int ID_W    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic_op_e        in_op,
  input  logic             in_sf,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [3:0]       in_nzcv,
  input  logic [3:0]       in_cond,
  input  logic [5:0]       in_immr,
  input  logic [5:0]       in_imms,
  input  logic [PRN_W-1:0] in_prn,
  input  logic [ID_W-1:0]  in_id,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_data,
  output logic [3:0]       out_nzcv,
  output logic             out_nzcv_valid,
  output logic [PRN_W-1:0] out_prn,
  output logic [ID_W-1:0]  out_id
);

  localparam logic [XLEN-1:0] LSB1 = {{(XLEN-1){1'b0}}, 1'b1};

  logic             out_valid_q, out_nzcv_valid_q;
  logic [XLEN-1:0]  out_data_q;
  logic [3:0]       out_nzcv_q;
  logic [PRN_W-1:0] out_prn_q;
  logic [ID_W-1:0]  out_id_q;

  logic advance, accept;

  // Execute-stage view: either the raw inputs or the stage-1 registers
  logic             e_valid, e_sf, e_cond;
  logic_op_e        e_op;
  logic [XLEN-1:0]  e_a, e_b;
  logic [5:0]       e_immr, e_imms;
  logic [PRN_W-1:0] e_prn;
  logic [ID_W-1:0]  e_id;

  logic             w64, nzcv_valid_d;
  logic [XLEN-1:0]  wmask, res_d, bfm_y;
  logic [3:0]       nzcv_d;

  assign advance  = !out_valid_q || out_ready;
  assign in_ready = advance && rst;
  assign accept   = in_valid && in_ready && !flush;

  generate
    if (LATENCY == 2) begin : g_lat2
      logic             s1_valid_q, s1_sf_q, s1_cond_q;
      logic_op_e        s1_op_q;
      logic [XLEN-1:0]  s1_a_q, s1_b_q;
      logic [5:0]       s1_immr_q, s1_imms_q;
      logic [PRN_W-1:0] s1_prn_q;
      logic [ID_W-1:0]  s1_id_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          s1_valid_q <= 1'b0;
          s1_sf_q    <= 1'b0;
          s1_cond_q  <= 1'b0;
          s1_op_q    <= OP_AND;
          s1_a_q     <= '0;
          s1_b_q     <= '0;
          s1_immr_q  <= '0;
          s1_imms_q  <= '0;
          s1_prn_q   <= '0;
          s1_id_q    <= '0;
        end else if (flush) begin
          s1_valid_q <= 1'b0;
        end else if (advance) begin
          s1_valid_q <= accept;
          if (accept) begin
            s1_sf_q   <= in_sf;
            s1_cond_q <= cond_eval(in_cond, in_nzcv);
            s1_op_q   <= in_op;
            s1_a_q    <= in_a;
            s1_b_q    <= in_b;
            s1_immr_q <= in_immr;
            s1_imms_q <= in_imms;
            s1_prn_q  <= in_prn;
            s1_id_q   <= in_id;
          end
        end
      end

      assign e_valid = s1_valid_q;
      assign e_sf    = s1_sf_q;
      assign e_cond  = s1_cond_q;
      assign e_op    = s1_op_q;
      assign e_a     = s1_a_q;
      assign e_b     = s1_b_q;
      assign e_immr  = s1_immr_q;
      assign e_imms  = s1_imms_q;
      assign e_prn   = s1_prn_q;
      assign e_id    = s1_id_q;
    end else begin : g_lat1
      assign e_valid = accept;
      assign e_sf    = in_sf;
      assign e_cond  = cond_eval(in_cond, in_nzcv);
      assign e_op    = in_op;
      assign e_a     = in_a;
      assign e_b     = in_b;
      assign e_immr  = in_immr;
      assign e_imms  = in_imms;
      assign e_prn   = in_prn;
      assign e_id    = in_id;
    end
  endgenerate

  fu_bfm #(.XLEN(XLEN)) u_bfm (
    .a_i      (e_a),
    .r_i      (e_immr),
    .s_i      (e_imms),
    .sf_i     (e_sf),
    .signed_i (e_op == OP_SBFM),
    .y_o      (bfm_y)
  );

  always_comb begin
    w64          = (XLEN == 64) && e_sf;
    wmask        = w64 ? '1 : XLEN'(32'hFFFF_FFFF);
    res_d        = '0;
    nzcv_d       = 4'b0000;
    nzcv_valid_d = 1'b0;
    case (e_op)
      OP_AND:   res_d = e_a & e_b;
      OP_ORR:   res_d = e_a | e_b;
      OP_EOR:   res_d = e_a ^ e_b;
      OP_BIC:   res_d = e_a & ~e_b;
      OP_ORN:   res_d = e_a | ~e_b;
      OP_MVN:   res_d = ~e_b;
      OP_ANDS:  res_d = e_a & e_b;
      OP_CSEL:  res_d = e_cond ? e_a : e_b;
      OP_CSINC: res_d = e_cond ? e_a : e_b + LSB1;
      OP_CSINV: res_d = e_cond ? e_a : ~e_b;
      OP_CSNEG: res_d = e_cond ? e_a : ~e_b + LSB1;
      OP_UBFM:  res_d = bfm_y;
      OP_SBFM:  res_d = bfm_y;
      default:  res_d = '0;
    endcase
    // Wrap-around arithmetic and 32-bit mode both resolve by truncating to W
    res_d = res_d & wmask;
    if (e_op == OP_ANDS) begin
      nzcv_valid_d = 1'b1;
      nzcv_d       = {(w64 ? res_d[XLEN-1] : res_d[31]), (res_d == '0), 2'b00};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      out_valid_q      <= 1'b0;
      out_data_q       <= '0;
      out_nzcv_q       <= 4'b0000;
      out_nzcv_valid_q <= 1'b0;
      out_prn_q        <= '0;
      out_id_q         <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (advance) begin
      out_valid_q <= e_valid;
      if (e_valid) begin
        out_data_q       <= res_d;
        out_nzcv_q       <= nzcv_d;
        out_nzcv_valid_q <= nzcv_valid_d;
        out_prn_q        <= e_prn;
        out_id_q         <= e_id;
      end
    end
  end

  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_nzcv       = out_nzcv_q;
  assign out_nzcv_valid = out_nzcv_valid_q;
  assign out_prn        = out_prn_q;
  assign out_id         = out_id_q;

endmodule

`default_nettype wire

// File: tb/tb_fu_logical_pipe.sv
// ============================================================================
// Module      : tb_fu_logical_pipe
// Description : Directed self-checking bench for fu_logical_pipe (LATENCY=2).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fu_logical_pipe;
  import fu_logical_pkg::*;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_sf;
  logic_op_e   in_op;
  logic [63:0] in_a, in_b, out_data;
  logic [3:0]  in_nzcv, in_cond, out_nzcv;
  logic [5:0]  in_immr, in_imms, in_id, out_id;
  logic [6:0]  in_prn, out_prn;
  logic        out_valid, out_ready, out_nzcv_valid;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  always #5 clk = ~clk;

  fu_logical_pipe #(.XLEN(64), .LATENCY(LAT), .PRN_W(7), .ID_W(6)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_sf(in_sf),
    .in_a(in_a), .in_b(in_b), .in_nzcv(in_nzcv), .in_cond(in_cond),
    .in_immr(in_immr), .in_imms(in_imms), .in_prn(in_prn), .in_id(in_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_nzcv(out_nzcv), .out_nzcv_valid(out_nzcv_valid),
    .out_prn(out_prn), .out_id(out_id)
  );

  task automatic drive(input logic_op_e op, input logic sf, input logic [63:0] a, b,
                       input logic [3:0] nzcv, cond, input logic [5:0] immr, imms,
                       input logic [6:0] prn, input logic [5:0] id);
    in_op = op; in_sf = sf; in_a = a; in_b = b; in_nzcv = nzcv; in_cond = cond;
    in_immr = immr; in_imms = imms; in_prn = prn; in_id = id; in_valid = 1'b1;
  endtask

  // Issues one op into an idle pipe and returns the first result seen (X if none).
  task automatic run_one(input logic_op_e op, input logic sf, input logic [63:0] a, b,
                         input logic [3:0] nzcv, cond, input logic [5:0] immr, imms,
                         output logic [63:0] d, output logic [3:0] f, output logic fv);
    logic got = 1'b0;
    d = 'x; f = 'x; fv = 1'bx;
    drive(op, sf, a, b, nzcv, cond, immr, imms, 7'd1, 6'd1);
    @(posedge clk); #1 in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid && !got) begin
        d = out_data; f = out_nzcv; fv = out_nzcv_valid; got = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(OP_AND, 1'b1, 64'h0, 64'h0, 4'h0, 4'h0, 6'd0, 6'd0, 7'd0, 6'd0);
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 64'h0) $display("FAIL rst_out_data got %h exp 0", out_data); else pass_cnt++;
    chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready_low got %b exp 0", in_ready); else pass_cnt++;
    rst = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_release_ready got %b exp 1", in_ready); else pass_cnt++;
  endtask

  task automatic test_logic_b2b();
    logic_op_e   ops[6] = '{OP_AND, OP_ORR, OP_EOR, OP_BIC, OP_ORN, OP_MVN};
    logic [63:0] exp[6] = '{64'h00F0_0000_00FF_0000, 64'hFFF0_00FF_FFFF_FF00,
                            64'hFF00_00FF_FF00_FF00, 64'hF000_0000_FF00_0000,
                            64'hF0FF_FF00_FFFF_00FF, 64'hF00F_FF00_FF00_00FF};
    int k;
    for (int c = 0; c < 8; c++) begin
      if (c < 6) drive(ops[c], 1'b1, 64'hF0F0_0000_FFFF_0000, 64'h0FF0_00FF_00FF_FF00,
                       4'h0, 4'h0, 6'd0, 6'd0, 7'd3, 6'(c));
      else in_valid = 1'b0;
      @(posedge clk); @(negedge clk);
      k = c - (LAT - 1);
      if (k >= 0 && k < 6) begin
        chk_cnt++; if (out_valid !== 1'b1 || out_id !== 6'(k))
          $display("FAIL b2b_order c=%0d got v=%b id=%0d exp v=1 id=%0d", c, out_valid, out_id, k); else pass_cnt++;
        chk_cnt++; if (out_data !== exp[k])
          $display("FAIL b2b_data op%0d got %h exp %h", k, out_data, exp[k]); else pass_cnt++;
        chk_cnt++; if (out_nzcv_valid !== 1'b0 || out_nzcv !== 4'h0)
          $display("FAIL b2b_flags op%0d got %b/%b exp 0/0000", k, out_nzcv_valid, out_nzcv); else pass_cnt++;
      end else begin
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL b2b_idle c=%0d got %b exp 0", c, out_valid); else pass_cnt++;
      end
    end
  endtask

  task automatic test_ands();
    logic [63:0] d; logic [3:0] f; logic fv;
    run_one(OP_ANDS, 1'b0, 64'hFFFF_FFFF_8000_0001, 64'hFFFF_FFFF_8000_0000, 4'hF, 4'h0, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'h8000_0000) $display("FAIL ands_neg_data got %h exp 0000000080000000", d); else pass_cnt++;
    chk_cnt++; if (f !== 4'b1000 || fv !== 1'b1) $display("FAIL ands_neg_flags got %b/%b exp 1000/1", f, fv); else pass_cnt++;
    run_one(OP_ANDS, 1'b0, 64'h1, 64'h2, 4'h0, 4'h0, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'h0) $display("FAIL ands_zero_data got %h exp 0", d); else pass_cnt++;
    chk_cnt++; if (f !== 4'b0100 || fv !== 1'b1) $display("FAIL ands_zero_flags got %b/%b exp 0100/1", f, fv); else pass_cnt++;
  endtask

  task automatic test_csel();
    logic [63:0] d; logic [3:0] f; logic fv;
    run_one(OP_CSNEG, 1'b1, 64'd5, 64'd3, 4'b0000, COND_GT, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'd5) $display("FAIL csneg_true got %h exp 5", d); else pass_cnt++;
    chk_cnt++; if (fv !== 1'b0 || f !== 4'h0) $display("FAIL csneg_flags got %b/%b exp 0/0000", fv, f); else pass_cnt++;
    run_one(OP_CSNEG, 1'b1, 64'd5, 64'd3, 4'b1000, COND_GT, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'hFFFF_FFFF_FFFF_FFFD) $display("FAIL csneg_false got %h exp fffffffffffffffd", d); else pass_cnt++;
    run_one(OP_CSINC, 1'b0, 64'h1234, 64'hFFFF_FFFF, 4'b0000, COND_EQ, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'h0) $display("FAIL csinc32_wrap got %h exp 0", d); else pass_cnt++;
    run_one(OP_CSEL, 1'b1, 64'hAAAA, 64'hBBBB, 4'b0000, COND_NV, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'hAAAA) $display("FAIL csel_nv got %h exp aaaa", d); else pass_cnt++;
    run_one(OP_CSEL, 1'b1, 64'hAAAA, 64'hBBBB, 4'b0100, COND_NE, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'hBBBB) $display("FAIL csel_ne got %h exp bbbb", d); else pass_cnt++;
    run_one(OP_CSINV, 1'b1, 64'd5, 64'd3, 4'b0010, COND_HI, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'd5) $display("FAIL csinv_hi_true got %h exp 5", d); else pass_cnt++;
    run_one(OP_CSINV, 1'b1, 64'd5, 64'd3, 4'b0110, COND_HI, 6'd0, 6'd0, d, f, fv);
    chk_cnt++; if (d !== 64'hFFFF_FFFF_FFFF_FFFC) $display("FAIL csinv_hi_false got %h exp fffffffffffffffc", d); else pass_cnt++;
  endtask

  task automatic test_bfm();
    logic [63:0] d; logic [3:0] f; logic fv;
    run_one(OP_SBFM, 1'b1, 64'h8000_0000_0000_0000, 64'h0, 4'h0, 4'h0, 6'd4, 6'd63, d, f, fv);
    chk_cnt++; if (d !== 64'hF800_0000_0000_0000) $display("FAIL asr4 got %h exp f800000000000000", d); else pass_cnt++;
    run_one(OP_UBFM, 1'b1, 64'h1, 64'h0, 4'h0, 4'h0, 6'd60, 6'd59, d, f, fv);
    chk_cnt++; if (d !== 64'h10) $display("FAIL lsl4 got %h exp 10", d); else pass_cnt++;
    run_one(OP_SBFM, 1'b0, 64'h80, 64'h0, 4'h0, 4'h0, 6'd0, 6'd7, d, f, fv);
    chk_cnt++; if (d !== 64'h0000_0000_FFFF_FF80) $display("FAIL sxtb32 got %h exp 00000000ffffff80", d); else pass_cnt++;
    run_one(OP_UBFM, 1'b0, 64'hFFFF_FFFF_0000_00F0, 64'h0, 4'h0, 4'h0, 6'd4, 6'd31, d, f, fv);
    chk_cnt++; if (d !== 64'hF) $display("FAIL lsr32 got %h exp f", d); else pass_cnt++;
  endtask

  task automatic test_stall();
    int got = 0;
    logic acc;
    out_ready = 1'b0;
    drive(OP_ORR, 1'b1, 64'h1000 + 64'd10, 64'h0, 4'h0, 4'h0, 6'd0, 6'd0, 7'd2, 6'd10);
    @(posedge clk); #1;
    drive(OP_ORR, 1'b1, 64'h1000 + 64'd11, 64'h0, 4'h0, 4'h0, 6'd0, 6'd0, 7'd2, 6'd11);
    @(posedge clk); #1;
    drive(OP_ORR, 1'b1, 64'h1000 + 64'd12, 64'h0, 4'h0, 4'h0, 6'd0, 6'd0, 7'd2, 6'd12);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk_cnt++; if (out_valid !== 1'b1 || out_id !== 6'd10 || out_data !== 64'h100A || in_ready !== 1'b0)
        $display("FAIL stall_hold cyc%0d got v=%b id=%0d d=%h rdy=%b exp v=1 id=10 d=100a rdy=0",
                 i, out_valid, out_id, out_data, in_ready); else pass_cnt++;
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (out_valid) begin
        chk_cnt++; if (got > 2 || out_id !== 6'(10 + got) || out_data !== 64'h1000 + 64'(10 + got))
          $display("FAIL stall_drain #%0d got id=%0d d=%h exp id=%0d", got, out_id, out_data, 10 + got); else pass_cnt++;
        got++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk_cnt++; if (got !== 3) $display("FAIL stall_count got %0d exp 3", got); else pass_cnt++;
  endtask

  task automatic test_flush();
    int seen = 0;
    out_ready = 1'b0;
    drive(OP_AND, 1'b1, 64'h20, 64'hFF, 4'h0, 4'h0, 6'd0, 6'd0, 7'd4, 6'd20);
    @(posedge clk); #1;
    drive(OP_AND, 1'b1, 64'h21, 64'hFF, 4'h0, 4'h0, 6'd0, 6'd0, 7'd4, 6'd21);
    @(posedge clk); #1;
    drive(OP_AND, 1'b1, 64'h22, 64'hFF, 4'h0, 4'h0, 6'd0, 6'd0, 7'd4, 6'd22);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_stall_clear got %b exp 0", out_valid); else pass_cnt++;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (out_valid) seen++; end
    chk_cnt++; if (seen !== 0) $display("FAIL flush_no_ghost got %0d results exp 0", seen); else pass_cnt++;
    seen = 0;
    @(posedge clk); #1;
    drive(OP_AND, 1'b1, 64'h23, 64'hFF, 4'h0, 4'h0, 6'd0, 6'd0, 7'd4, 6'd23);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (out_valid) seen++; end
    chk_cnt++; if (seen !== 0) $display("FAIL flush_drop_input got %0d results exp 0", seen); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    int seen = 0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    drive(OP_ANDS, 1'b0, 64'h8000_0000, 64'h8000_0000, 4'h0, 4'h0, 6'd0, 6'd0, 7'h55, 6'd30);
    @(posedge clk); #1;
    drive(OP_ORR, 1'b1, 64'h31, 64'h0, 4'h0, 4'h0, 6'd0, 6'd0, 7'h56, 6'd31);
    @(posedge clk); #1 in_valid = 1'b0;
    @(negedge clk);
    chk_cnt++; if (out_valid !== 1'b1 || out_nzcv !== 4'b1000 || out_prn !== 7'h55)
      $display("FAIL midrst_pre got v=%b nzcv=%b prn=%h exp 1/1000/55", out_valid, out_nzcv, out_prn); else pass_cnt++;
    rst = 1'b0;
    @(posedge clk); #1;
    chk_cnt++; if (out_valid !== 1'b0) $display("FAIL midrst_valid got %b exp 0", out_valid); else pass_cnt++;
    chk_cnt++; if (out_data !== 64'h0) $display("FAIL midrst_data got %h exp 0", out_data); else pass_cnt++;
    chk_cnt++; if (out_nzcv !== 4'h0 || out_nzcv_valid !== 1'b0)
      $display("FAIL midrst_flags got %b/%b exp 0000/0", out_nzcv, out_nzcv_valid); else pass_cnt++;
    chk_cnt++; if (out_prn !== 7'h0 || out_id !== 6'h0)
      $display("FAIL midrst_tags got prn=%h id=%h exp 0/0", out_prn, out_id); else pass_cnt++;
    @(negedge clk);
    rst = 1'b1; out_ready = 1'b1; #1;
    chk_cnt++; if (in_ready !== 1'b1) $display("FAIL midrst_ready got %b exp 1", in_ready); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (out_valid) seen++; end
    chk_cnt++; if (seen !== 0) $display("FAIL midrst_discard got %0d results exp 0", seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    @(posedge clk); #1;
    test_logic_b2b();
    test_ands();
    test_csel();
    test_bfm();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

endmodule

`default_nettype wire
